// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package fetch_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Byte address to word index, wrapped to a power-of-two memory depth.
    function automatic logic [31:0] pc_to_widx(input logic [63:0] pc, input int unsigned depth);
        return pc[33:2] & (depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count; head is the oldest entry.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC, synchronous-read IMEM, credit-gated prefetch FIFO, redirect flush.
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter int              IMEM_DEPTH = 128,
    parameter int              FIFO_DEPTH = 4,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [INST_W-1:0]             imem_wdata,
    input  logic                          redirect_valid,
    input  logic [PC_W-1:0]               redirect_pc,
    input  logic                          inst_ready,
    output logic                          inst_valid,
    output logic [INST_W-1:0]             inst,
    output logic [PC_W-1:0]               inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fetch_err
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = INST_W + PC_W;

    logic [INST_W-1:0] imem [IMEM_DEPTH];

    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   rd_pc;
    logic              rd_pending;
    logic [INST_W-1:0] rd_data;
    logic [IDX_W-1:0]  widx;

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W-1:0]  occupancy;

    logic [ENT_W-1:0]  fifo_head;
    logic [INST_W-1:0] head_inst;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] last_inst;
    logic [PC_W-1:0]   last_pc;

    assign widx       = IDX_W'(pc_to_widx(64'(fetch_pc), IMEM_DEPTH));
    assign inst_valid = (fifo_count != '0);

    // Redirect dominates: no pop, no push, no issue in its cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pop       = 1'b0;
        push      = 1'b0;
        issue     = 1'b0;
        occupancy = '0;
        if (!redirect_valid) begin
            pop       = inst_valid && inst_ready;
            push      = rd_pending;
            // Credit check: entries held plus the read in flight, minus what leaves now.
            occupancy = fifo_count + CNT_W'(rd_pending) - CNT_W'(pop);
            issue     = (occupancy < CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc   <= RESET_PC;
            rd_pc      <= '0;
            rd_pending <= 1'b0;
            fetch_err  <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc   <= {redirect_pc[PC_W-1:2], 2'b00};
            rd_pending <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) fetch_err <= 1'b1;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_W'(4);
                rd_pc    <= fetch_pc;
            end
        end
    end

    // Same-word write and read in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     rd_data <= NOP;
        else if (issue) rd_data <= imem[widx];
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data ({rd_pc, rd_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign {head_pc, head_inst} = fifo_head;

    // Output holds the last presented instruction while the FIFO is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_inst <= '0;
            last_pc   <= '0;
        end else if (inst_valid) begin
            last_inst <= head_inst;
            last_pc   <= head_pc;
        end
    end

    assign inst    = inst_valid ? head_inst : last_inst;
    assign inst_pc = inst_valid ? head_pc   : last_pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_we;
    logic [6:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  fifo_count;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    ifetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fifo_count     (fifo_count),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: memory image, fetch PC, one in-flight read, buffered queue.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic [31:0] m_mem [128];
    entry_t      m_q[$];
    logic [31:0] m_pc;
    bit          m_pend;
    entry_t      m_pend_e;
    bit          m_err;
    entry_t      m_last;

    task automatic model_reset();
        m_q.delete();
        m_pc     = 32'h0;
        m_pend   = 1'b0;
        m_pend_e = '0;
        m_err    = 1'b0;
        m_last   = '0;
    endtask

    task automatic model_edge(input bit redir, input logic [31:0] rpc, input bit ready,
                              input bit we, input logic [6:0] wa, input logic [31:0] wd);
        bit pop;
        int occ;
        pop = (m_q.size() != 0) && ready && !redir;
        if (m_q.size() != 0) m_last = m_q[0];
        if (redir) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc   = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) m_err = 1'b1;
        end else begin
            occ = int'(m_q.size()) + int'(m_pend) - int'(pop);
            if (pop) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_e);
            if (occ < 4) begin
                m_pend_e = '{inst: m_mem[m_pc[8:2]], pc: m_pc};
                m_pc     = m_pc + 32'd4;
                m_pend   = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
        end
        if (we) m_mem[wa] = wd;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        entry_t e;
        e = (m_q.size() != 0) ? m_q[0] : m_last;
        check({tag, ".valid"}, 64'(inst_valid), 64'(m_q.size() != 0));
        check({tag, ".count"}, 64'(fifo_count), 64'(m_q.size()));
        check({tag, ".err"},   64'(fetch_err),  64'(m_err));
        check({tag, ".inst"},  64'(inst),       64'(e.inst));
        check({tag, ".pc"},    64'(inst_pc),    64'(e.pc));
    endtask

    // Drive one cycle of inputs, take the edge, update the model, compare #1 later.
    task automatic step(input string tag, input bit redir, input logic [31:0] rpc, input bit ready,
                        input bit we, input logic [6:0] wa, input logic [31:0] wd);
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = ready;
        imem_we        = we;
        imem_waddr     = wa;
        imem_wdata     = wd;
        @(posedge clk);
        model_edge(redir, rpc, ready, we, wa, wd);
        #1;
        compare_all(tag);
    endtask

    task automatic run(input string tag, input bit ready);
        step(tag, 1'b0, 32'h0, ready, 1'b0, 7'h0, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        imem_we        = 1'b0;
        reset          = 1'b0;
        #1;
        model_reset();
        check({tag, ".valid0"}, 64'(inst_valid), 64'h0);
        check({tag, ".inst0"},  64'(inst),       64'h0);
        check({tag, ".pc0"},    64'(inst_pc),    64'h0);
        check({tag, ".count0"}, 64'(fifo_count), 64'h0);
        check({tag, ".err0"},   64'(fetch_err),  64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bit          r_redir;
        bit          r_ready;
        bit          r_we;
        logic [31:0] r_pc;
        logic [6:0]  r_wa;

        reset          = 1'b0;
        imem_we        = 1'b0;
        imem_waddr     = '0;
        imem_wdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        model_reset();
        #1;
        compare_all("reset");

        // Load IMEM while held in reset: words 0..7 = 0x100+i, the rest random.
        for (int i = 0; i < 128; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 7'(i);
            imem_wdata = (i < 8) ? 32'h100 + 32'(i) : $urandom;
            m_mem[i]   = imem_wdata;
            @(posedge clk);
            #1;
        end
        imem_we = 1'b0;
        compare_all("reset.after_load");
        reset = 1'b1;

        // Streaming: valid after the second edge, then one per cycle.
        run("first.e1", 1'b1);
        check("first.e1.valid", 64'(inst_valid), 64'h0);
        run("first.e2", 1'b1);
        check("first.e2.valid", 64'(inst_valid), 64'h1);
        check("first.e2.inst",  64'(inst),       64'h100);
        check("first.e2.pc",    64'(inst_pc),    64'h0);
        for (int k = 1; k < 8; k++) begin
            run("stream", 1'b1);
            check("stream.inst", 64'(inst),    64'(32'h100 + 32'(k)));
            check("stream.pc",   64'(inst_pc), 64'(32'(4 * k)));
        end

        // Stall: FIFO saturates, head stable, then drains in order with no gap.
        do_reset("rst1");
        for (int k = 0; k < 12; k++) run("stall", 1'b0);
        check("stall.count", 64'(fifo_count), 64'h4);
        check("stall.inst",  64'(inst),       64'h100);
        for (int k = 0; k < 8; k++) begin
            check("drain.valid", 64'(inst_valid), 64'h1);
            check("drain.inst",  64'(inst),       64'(32'h100 + 32'(k)));
            check("drain.pc",    64'(inst_pc),    64'(32'(4 * k)));
            run("drain", 1'b1);
        end

        // Redirect to 0x14 while FIFO holds pcs 0x0..0xC.
        do_reset("rst2");
        for (int k = 0; k < 6; k++) run("fill", 1'b0);
        check("fill.count", 64'(fifo_count), 64'h4);
        step("redir14", 1'b1, 32'h14, 1'b0, 1'b0, 7'h0, 32'h0);
        check("redir14.valid", 64'(inst_valid), 64'h0);
        check("redir14.count", 64'(fifo_count), 64'h0);
        run("redir14.e1", 1'b1);
        check("redir14.e1.valid", 64'(inst_valid), 64'h0);
        run("redir14.e2", 1'b1);
        check("redir14.e2.inst", 64'(inst),    64'h105);
        check("redir14.e2.pc",   64'(inst_pc), 64'h14);

        // Redirect coinciding with a handshake.
        step("redir_hs", 1'b1, 32'h8, 1'b1, 1'b0, 7'h0, 32'h0);
        check("redir_hs.count", 64'(fifo_count), 64'h0);
        run("redir_hs.e1", 1'b1);
        run("redir_hs.e2", 1'b1);
        check("redir_hs.pc",   64'(inst_pc), 64'h8);
        check("redir_hs.inst", 64'(inst),    64'h102);

        // PC wraps through 2^32, IMEM index wraps through 127 -> 0.
        step("wrap", 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 7'h0, 32'h0);
        run("wrap.e1", 1'b1);
        run("wrap.e2", 1'b1);
        check("wrap.pc0", 64'(inst_pc), 64'hFFFF_FFF8);
        run("wrap.e3", 1'b1);
        check("wrap.pc1", 64'(inst_pc), 64'hFFFF_FFFC);
        run("wrap.e4", 1'b1);
        check("wrap.pc2",   64'(inst_pc), 64'h0);
        check("wrap.inst2", 64'(inst),    64'h100);

        // Misaligned redirect: sticky error, fetch from the aligned word.
        step("mis", 1'b1, 32'h16, 1'b1, 1'b0, 7'h0, 32'h0);
        check("mis.err", 64'(fetch_err), 64'h1);
        run("mis.e1", 1'b1);
        run("mis.e2", 1'b1);
        check("mis.pc",   64'(inst_pc), 64'h14);
        check("mis.inst", 64'(inst),    64'h105);
        for (int k = 0; k < 3; k++) run("mis.hold", 1'b1);
        check("mis.sticky", 64'(fetch_err), 64'h1);

        // Reset mid-operation with three entries buffered.
        for (int k = 0; k < 10 && m_q.size() != 3; k++) run("grow3", 1'b0);
        check("grow3.count", 64'(fifo_count), 64'h3);
        do_reset("rst3");
        run("restart.e1", 1'b1);
        run("restart.e2", 1'b1);
        check("restart.pc",   64'(inst_pc), 64'h0);
        check("restart.inst", 64'(inst),    64'h100);

        // Randomized traffic: backpressure, redirects, IMEM writes including collisions.
        for (int n = 0; n < 400; n++) begin
            r_ready = ($urandom_range(0, 3) != 0);
            r_redir = ($urandom_range(0, 15) == 0);
            r_pc    = $urandom;
            if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
            r_we = ($urandom_range(0, 5) == 0);
            r_wa = ($urandom_range(0, 1) != 0) ? m_pc[8:2] : 7'($urandom_range(0, 127));
            step("rand", r_redir, r_pc, r_ready, r_we, r_wa, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
